// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM dead-time inserter.
package pwm_pkg;

    localparam int PWM_DT_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DT_TO_HI,
        ST_HI_ON,
        ST_DT_TO_LO,
        ST_LO_ON,
        ST_FAULT
    } pwm_dt_state_t;

endpackage

// File: rtl/pwm_dt_timer.sv
// Loadable dead-time down-counter; a load of 0 is clamped to 1 and the count
// parks at 1, so it never wraps.
module pwm_dt_timer
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = PWM_DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DT_WIDTH-1:0] value,
    output logic                done
);

    logic [DT_WIDTH-1:0] cnt_q;
    logic [DT_WIDTH-1:0] cnt_d;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (value == '0) ? DT_WIDTH'(1) : value;
        end else if (cnt_q > DT_WIDTH'(1)) begin
            cnt_d = cnt_q - DT_WIDTH'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments; reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q <= DT_WIDTH'(1));

endmodule

// File: rtl/pwm_deadtime_inserter.sv
// Complementary gate driver with dead-time insertion, short-pulse swallowing
// and a latched fault that holds both gates low until cleared.
module pwm_deadtime_inserter
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = PWM_DT_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault,
    input  logic                fault_clear,
    output logic                out_hi,
    output logic                out_lo,
    output logic                fault_latched,
    output logic                pulse_drop
);

    pwm_dt_state_t state_q, state_d;
    logic pwm_q;
    logic out_hi_q, out_hi_d;
    logic out_lo_q, out_lo_d;
    logic fault_latched_q, fault_latched_d;
    logic pulse_drop_q, pulse_drop_d;
    logic load_d;
    logic dt_done;

    pwm_dt_timer #(.DT_WIDTH(DT_WIDTH)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load_d),
        .value (dead_time),
        .done  (dt_done)
    );

    always_comb begin
        state_d      = state_q;
        load_d       = 1'b0;
        pulse_drop_d = 1'b0;
        if (fault) begin
            state_d = ST_FAULT;
        end else if (state_q == ST_FAULT) begin
            if (fault_clear) state_d = ST_OFF;
        end else if (!enable) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = pwm_q ? ST_DT_TO_HI : ST_DT_TO_LO;
                    load_d  = 1'b1;
                end
                ST_LO_ON: if (pwm_q) begin
                    state_d = ST_DT_TO_HI;
                    load_d  = 1'b1;
                end
                ST_HI_ON: if (!pwm_q) begin
                    state_d = ST_DT_TO_LO;
                    load_d  = 1'b1;
                end
                // A reversal of the input aborts the gap and returns to the side that was on.
                ST_DT_TO_HI: begin
                    if (!pwm_q) begin
                        state_d      = ST_LO_ON;
                        pulse_drop_d = 1'b1;
                    end else if (dt_done) begin
                        state_d = ST_HI_ON;
                    end
                end
                ST_DT_TO_LO: begin
                    if (pwm_q) begin
                        state_d      = ST_HI_ON;
                        pulse_drop_d = 1'b1;
                    end else if (dt_done) begin
                        state_d = ST_LO_ON;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
        out_hi_d        = (state_d == ST_HI_ON);
        out_lo_d        = (state_d == ST_LO_ON);
        fault_latched_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_OFF;
            pwm_q           <= 1'b0;
            out_hi_q        <= 1'b0;
            out_lo_q        <= 1'b0;
            fault_latched_q <= 1'b0;
            pulse_drop_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pwm_q           <= pwm_in;
            out_hi_q        <= out_hi_d;
            out_lo_q        <= out_lo_d;
            fault_latched_q <= fault_latched_d;
            pulse_drop_q    <= pulse_drop_d;
        end
    end

    assign out_hi        = out_hi_q;
    assign out_lo        = out_lo_q;
    assign fault_latched = fault_latched_q;
    assign pulse_drop    = pulse_drop_q;

endmodule

// File: tb/tb_pwm_deadtime_inserter.sv
// Directed and randomised bench for pwm_deadtime_inserter against a
// side/gap-length reference model.
module tb_pwm_deadtime_inserter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       pwm_in;
    logic [7:0] dead_time;
    logic       fault;
    logic       fault_clear;
    logic       out_hi;
    logic       out_lo;
    logic       fault_latched;
    logic       pulse_drop;

    int errors = 0;
    int checks = 0;

    // Reference model: which side is on (0 none, 1 lo, 2 hi), pending gap.
    bit m_pwm;
    bit m_fault;
    bit m_drop;
    int m_on;
    int m_gap_to;
    int m_gap_left;

    pwm_deadtime_inserter #(.DT_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .fault         (fault),
        .fault_clear   (fault_clear),
        .out_hi        (out_hi),
        .out_lo        (out_lo),
        .fault_latched (fault_latched),
        .pulse_drop    (pulse_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pwm = 1'b0; m_fault = 1'b0; m_drop = 1'b0;
        m_on = 0; m_gap_to = 0; m_gap_left = 0;
    endtask

    task automatic model_step();
        int want;
        want   = m_pwm ? 2 : 1;
        m_drop = 1'b0;
        if (fault) begin
            m_fault = 1'b1; m_on = 0; m_gap_left = 0;
        end else if (m_fault) begin
            if (fault_clear) m_fault = 1'b0;
        end else if (!enable) begin
            m_on = 0; m_gap_left = 0;
        end else if (m_gap_left > 0) begin
            if (want != m_gap_to) begin
                m_on = want; m_gap_left = 0; m_drop = 1'b1;
            end else if (m_gap_left <= 1) begin
                m_on = m_gap_to; m_gap_left = 0;
            end else begin
                m_gap_left--;
            end
        end else if (m_on != want) begin
            m_on       = 0;
            m_gap_to   = want;
            m_gap_left = (dead_time == 8'd0) ? 1 : int'(dead_time);
        end
        m_pwm = pwm_in;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check("model_hi",    out_hi,        32'(m_on == 2));
        check("model_lo",    out_lo,        32'(m_on == 1));
        check("model_fault", fault_latched, 32'(m_fault));
        check("model_drop",  pulse_drop,    32'(m_drop));
    endtask

    // Drive pwm_in to level, count both-low cycles until the target side turns on.
    task automatic run_transition(input bit level, input int exp_gap, input int change_at,
                                  input int new_dt, input string tag);
        int gap;
        bit reached;
        gap = 0; reached = 1'b0;
        pwm_in = level;
        for (int i = 1; i <= 600 && !reached; i++) begin
            tick();
            if (i == change_at) dead_time = 8'(new_dt);
            if (level ? out_hi : out_lo) reached = 1'b1;
            else if (!out_hi && !out_lo) gap++;
        end
        check({tag, "_reached"}, 32'(reached), 1);
        check({tag, "_gap"}, gap, exp_gap);
    endtask

    initial begin
        int hi_cnt, drop_cnt;
        int last_side, cur, prev_cur, gap_len, gap_d;
        bit en_edge, f_edge;
        logic [7:0] dt_edge;

        rst = 1'b1; enable = 1'b0; pwm_in = 1'b0; dead_time = 8'd4;
        fault = 1'b0; fault_clear = 1'b0;
        model_reset();
        #7;
        check("rst_hi", out_hi, 0);
        check("rst_lo", out_lo, 0);
        check("rst_fault", fault_latched, 0);
        check("rst_drop", pulse_drop, 0);
        #5 rst = 1'b0;

        // Start-up into the low side with dead_time=4.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("start_gap_lo", out_lo, 0);
            check("start_gap_hi", out_hi, 0);
        end
        tick();
        check("start_lo_on", out_lo, 1);
        check("start_hi_off", out_hi, 0);

        // Rise/fall latency with dead_time=3.
        dead_time = 8'd3;
        pwm_in = 1'b1;
        tick(); check("rise_N_lo", out_lo, 1);
        tick(); check("rise_N1_lo", out_lo, 0);
        tick(); check("rise_N2_hi", out_hi, 0);
        tick(); check("rise_N3_hi", out_hi, 0);
        tick(); check("rise_N4_hi", out_hi, 1);
        tick(); tick();
        pwm_in = 1'b0;
        tick(); check("fall_M_hi", out_hi, 1);
        tick(); check("fall_M1_hi", out_hi, 0);
        tick(); tick(); check("fall_M3_lo", out_lo, 0);
        tick(); check("fall_M4_lo", out_lo, 1);

        // Short pulse swallowed with dead_time=10.
        dead_time = 8'd10;
        hi_cnt = 0; drop_cnt = 0;
        pwm_in = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) pwm_in = 1'b0;
            tick();
            hi_cnt   += int'(out_hi);
            drop_cnt += int'(pulse_drop);
        end
        check("short_hi_never", hi_cnt, 0);
        check("short_drop_once", drop_cnt, 1);
        check("short_lo_back", out_lo, 1);

        // Dead-time boundaries and mid-gap change.
        dead_time = 8'd0;
        run_transition(1'b1, 1, 0, 0, "dt0_rise");
        run_transition(1'b0, 1, 0, 0, "dt0_fall");
        dead_time = 8'd255;
        run_transition(1'b1, 255, 0, 0, "dt255_rise");
        dead_time = 8'd20;
        run_transition(1'b0, 20, 5, 2, "dt_midchange");

        // Fault during HI_ON, clear held off by fault, then a full restart gap.
        dead_time = 8'd3;
        run_transition(1'b1, 3, 0, 0, "pre_fault");
        fault = 1'b1;
        tick();
        check("fault_hi", out_hi, 0);
        check("fault_lo", out_lo, 0);
        check("fault_latch", fault_latched, 1);
        fault_clear = 1'b1;
        tick(); tick();
        check("fault_hold", fault_latched, 1);
        fault = 1'b0;
        tick();
        check("fault_cleared", fault_latched, 0);
        check("fault_off_hi", out_hi, 0);
        fault_clear = 1'b0;
        run_transition(1'b1, 3, 0, 0, "fault_restart");

        // Async reset mid DT_TO_HI, then again during HI_ON.
        run_transition(1'b0, 3, 0, 0, "pre_rst");
        pwm_in = 1'b1;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_dt_hi", out_hi, 0);
        check("arst_dt_lo", out_lo, 0);
        enable = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        enable = 1'b1;
        run_transition(1'b1, 3, 0, 0, "post_rst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_hi_on", out_hi, 0);
        check("arst_fault", fault_latched, 0);
        tick();
        #2 rst = 1'b0;

        // Randomised run: model match, no overlap, every side change gap >= D.
        last_side = 0; prev_cur = 0; gap_len = 0; gap_d = 1;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) pwm_in = ~pwm_in;
            if ($urandom_range(0, 63) == 0) dead_time = 8'($urandom_range(0, 12));
            enable      = ($urandom_range(0, 199) != 0);
            fault       = ($urandom_range(0, 499) == 0);
            fault_clear = ($urandom_range(0, 3) == 0);
            dt_edge = dead_time; en_edge = enable; f_edge = fault;
            tick();
            check("no_overlap", 32'(out_hi & out_lo), 0);
            cur = out_hi ? 2 : (out_lo ? 1 : 0);
            if (!en_edge || f_edge || fault_latched) begin
                last_side = 0;
            end else if (cur == 0) begin
                if (prev_cur != 0) begin
                    gap_len = 1;
                    gap_d   = (dt_edge == 8'd0) ? 1 : int'(dt_edge);
                end else begin
                    gap_len++;
                end
            end else begin
                if (prev_cur == 0 && last_side != 0 && cur != last_side)
                    check("gap_ge_d", 32'(gap_len >= gap_d), 1);
                last_side = cur;
            end
            prev_cur = cur;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
